bus_master_if: RTL and testbench

CPU-side bus master that sits directly upstream of bus_memory and drives its memory-mapped read/write interface (address, byteenable, writedata, read, write, waitrequest, readdata).
- Accepts one load/store request at a time from the MIPS core.
- Converts byte/half/word accesses into word-aligned bus cycles with byte lanes.
- Holds the cycle while waitrequest is high.
- Returns lane-extracted, sign- or zero-extended read data with a completion pulse.

---
 rtl/bus_master_pkg.sv | 65 ++++++
 rtl/bus_lane_extract.sv | 43 ++++
 rtl/bus_master_if.sv | 169 ++++++++++++++++
 tb/tb_bus_master_if.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared types and helpers for the CPU-side bus master.
//   state_t    : master FSM states
//   SZ_*       : request size encodings (3 is reserved and always misaligned)
//   bus_cmd_t  : registered bus cycle payload (address, lanes, store data)
//   be_for     : byte-lane mask for a size/offset pair (little-endian)
//   misaligned : request alignment check
//   wdata_lanes: store data replicated across the lanes it may occupy
package bus_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    function automatic logic [BE_W-1:0] be_for(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << offset;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_W-1:0] wdata_lanes(input logic [1:0]        size,
                                                      input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/bus_lane_extract.sv
// Selects the addressed byte/half lane of a bus read word and extends it to 32 bits.
//   readdata : raw 32-bit word from the slave
//   offset   : byte offset of the access within the word
//   size     : SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext : 1 = sign-extend, 0 = zero-extend
//   data     : extended result (combinational)
module bus_lane_extract
    import bus_master_pkg::*;
(
    input  logic [DATA_W-1:0] readdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select
    always_comb begin
        byte_sel = readdata[7:0];
        case (offset)
            2'd0: byte_sel = readdata[7:0];
            2'd1: byte_sel = readdata[15:8];
            2'd2: byte_sel = readdata[23:16];
            2'd3: byte_sel = readdata[31:24];
            default: byte_sel = readdata[7:0];
        endcase
        half_sel = offset[1] ? readdata[31:16] : readdata[15:0];
    end

    // Width extension
    always_comb begin
        data = readdata;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = readdata;
        endcase
    end

endmodule

// File: rtl/bus_master_if.sv
// CPU-side bus master: turns one load/store request at a time into a
// word-aligned memory-mapped bus cycle and returns an extended load result.
//   clk, reset            : clock, async active-low reset
//   req_*                 : CPU request (req_ready is decoded from state)
//   resp_valid/rdata/err  : one-cycle completion pulse with load data / error
//   address, byteenable,
//   writedata, read, write: bus cycle driven to the slave
//   waitrequest, readdata : slave stall and read data
module bus_master_if
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    state_t            state_q, state_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [DATA_W-1:0] lane_data;

    // Load path lane selection / extension from the live bus data
    bus_lane_extract u_lane (
        .readdata (readdata),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (sgn_q),
        .data     (lane_data)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            sgn_q        <= 1'b0;
            off_q        <= 2'd0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            read_q       <= read_d;
            write_q      <= write_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        read_d       = read_q;
        write_d      = write_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned(req_size, req_addr[1:0])) begin
                        // Rejected without touching the bus
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        cmd_d.addr  = {req_addr[ADDR_W-1:2], 2'b00};
                        cmd_d.be    = be_for(req_size, req_addr[1:0]);
                        cmd_d.wdata = wdata_lanes(req_size, req_wdata);
                        size_d      = req_size;
                        sgn_d       = req_signed;
                        off_d       = req_addr[1:0];
                        read_d      = ~req_write;
                        write_d     = req_write;
                        cnt_d       = '0;
                        state_d     = BUS;
                    end
                end
            end

            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = read_q ? lane_data : '0;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort once the stall count reaches the limit
                    if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = cmd_q.addr;
    assign byteenable = cmd_q.be;
    assign writedata  = cmd_q.wdata;
    assign read       = read_q;
    assign write      = write_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: default instance for the transfer cases
// and a TIMEOUT=4 instance whose slave never releases waitrequest.
module tb_bus_master_if;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        req_valid_t;
    logic        req_ready_t;
    logic        resp_valid_t;
    logic [31:0] resp_rdata_t;
    logic        resp_err_t;
    logic [31:0] address_t;
    logic [3:0]  byteenable_t;
    logic [31:0] writedata_t;
    logic        read_t;
    logic        write_t;

    int n_checks;
    int n_errors;

    bus_master_if u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .address     (address),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    bus_master_if #(.TIMEOUT(4), .CNT_W(3)) u_dut_to (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid_t),
        .req_ready   (req_ready_t),
        .req_write   (1'b0),
        .req_size    (2'd2),
        .req_signed  (1'b0),
        .req_addr    (32'h0000_0100),
        .req_wdata   (32'h0),
        .resp_valid  (resp_valid_t),
        .resp_rdata  (resp_rdata_t),
        .resp_err    (resp_err_t),
        .address     (address_t),
        .byteenable  (byteenable_t),
        .writedata   (writedata_t),
        .read        (read_t),
        .write       (write_t),
        .waitrequest (1'b1),
        .readdata    (32'hFFFF_FFFF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accepting edge
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        req_valid_t = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Reset values
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", 32'(byteenable), 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_strobes", 32'({read, write}), 32'd0);

        // Word store, zero wait states
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("sw_ready", 32'(req_ready), 32'd0);
        chk("sw_strobes", 32'({read, write}), 32'b01);
        chk("sw_addr", address, 32'h0000_0010);
        chk("sw_be", 32'(byteenable), 32'hF);
        chk("sw_wdata", writedata, 32'hDEAD_BEEF);
        chk("sw_resp_early", 32'(resp_valid), 32'd0);
        step();
        chk("sw_strobe_drop", 32'({read, write}), 32'b00);
        chk("sw_resp_valid", 32'(resp_valid), 32'd1);
        chk("sw_resp_err", 32'(resp_err), 32'd0);
        chk("sw_ready_resp", 32'(req_ready), 32'd0);
        step();
        chk("sw_resp_pulse", 32'(resp_valid), 32'd0);
        chk("sw_ready_back", 32'(req_ready), 32'd1);

        // Signed byte load from lane 3
        readdata = 32'h8011_2233;
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0);
        chk("lbs_strobes", 32'({read, write}), 32'b10);
        chk("lbs_addr", address, 32'h0000_0010);
        chk("lbs_be", 32'(byteenable), 32'b1000);
        step();
        chk("lbs_resp_valid", 32'(resp_valid), 32'd1);
        chk("lbs_rdata", resp_rdata, 32'hFFFF_FF80);
        step();

        // Same load, unsigned
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0);
        step();
        chk("lbu_resp_valid", 32'(resp_valid), 32'd1);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        step();

        // Signed half load from upper lane
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0);
        chk("lhs_be", 32'(byteenable), 32'b1100);
        step();
        chk("lhs_rdata", resp_rdata, 32'hFFFF_8011);
        step();

        // Half store to upper lane
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD);
        chk("sh_addr", address, 32'h0000_0020);
        chk("sh_be", 32'(byteenable), 32'b1100);
        chk("sh_wdata", writedata, 32'hABCD_ABCD);
        chk("sh_strobes", 32'({read, write}), 32'b01);
        step();
        chk("sh_resp_err", 32'(resp_err), 32'd0);
        step();

        // Byte store replicates the byte
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0031, 32'h1234_5678);
        chk("sb_be", 32'(byteenable), 32'b0010);
        chk("sb_wdata", writedata, 32'h7878_7878);
        step();
        step();

        // Word load with five wait states
        waitrequest = 1'b1;
        readdata    = 32'h1111_1111;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wait_read_%0d", i), 32'(read), 32'd1);
            chk($sformatf("wait_addr_%0d", i), address, 32'h0000_0040);
            chk($sformatf("wait_resp_%0d", i), 32'(resp_valid), 32'd0);
            step();
        end
        waitrequest = 1'b0;
        readdata    = 32'hCAFE_F00D;
        chk("wait_read_5", 32'(read), 32'd1);
        chk("wait_addr_5", address, 32'h0000_0040);
        step();
        readdata = 32'h0;
        chk("wait_read_drop", 32'(read), 32'd0);
        chk("wait_resp_valid", 32'(resp_valid), 32'd1);
        chk("wait_rdata", resp_rdata, 32'hCAFE_F00D);
        chk("wait_err", 32'(resp_err), 32'd0);
        step();

        // Misaligned word load: immediate error, no bus cycle
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0005, 32'h0);
        chk("mis_strobes", 32'({read, write}), 32'd0);
        chk("mis_resp_valid", 32'(resp_valid), 32'd1);
        chk("mis_resp_err", 32'(resp_err), 32'd1);
        chk("mis_rdata", resp_rdata, 32'h0);
        step();
        chk("mis_ready_back", 32'(req_ready), 32'd1);

        // Reserved size is always rejected
        issue(1'b1, 2'd3, 1'b0, 32'h0000_0008, 32'h0);
        chk("sz3_strobes", 32'({read, write}), 32'd0);
        chk("sz3_resp_err", 32'(resp_err), 32'd1);
        step();

        // Timeout instance: stuck waitrequest aborts after four stall cycles
        req_valid_t = 1'b1;
        step();
        req_valid_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_read_%0d", i), 32'(read_t), 32'd1);
            chk($sformatf("to_resp_%0d", i), 32'(resp_valid_t), 32'd0);
            step();
        end
        chk("to_read_drop", 32'(read_t), 32'd0);
        chk("to_resp_valid", 32'(resp_valid_t), 32'd1);
        chk("to_resp_err", 32'(resp_err_t), 32'd1);
        chk("to_rdata", resp_rdata_t, 32'h0);
        step();
        chk("to_ready_back", 32'(req_ready_t), 32'd1);

        // Reset pulsed mid-BUS drops the strobe asynchronously
        waitrequest = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0);
        chk("rb_read_before", 32'(read), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rb_read_async", 32'(read), 32'd0);
        chk("rb_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        waitrequest = 1'b0;
        step();
        chk("rb_ready_after", 32'(req_ready), 32'd1);
        chk("rb_no_resp", 32'(resp_valid), 32'd0);

        // Recovery transaction after reset
        readdata = 32'h0BAD_F00D;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0084, 32'h0);
        chk("rec_addr", address, 32'h0000_0084);
        step();
        chk("rec_rdata", resp_rdata, 32'h0BAD_F00D);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
